dca_matrix_load_sequencer: RTL
==============================

// Module: dca_matrix_load_sequencer
// PURPOSE
//  Sequences matrix-row loads for the DCA matrix LSU read path. Takes one command (base, stride, rows, beats),
//  issues one AXI AR burst per row and pushes matching txn info to the row collector in the same cycle.
//  Caps in-flight rows with a credit counter that is returned by the collector's row_done.
//  Sits between the LSU command decoder and the AXI AR channel / row-collector txn FIFO.
// PARAMETERS
//  BW_ADDR          32  address width
//  BW_AXI_DATA      32  AXI data width; sets arsize = log2(BW_AXI_DATA/8)
//  MAX_NUM_AXI_DATA  4  max beats per row (row buffer capacity)
//  MAX_OUTSTANDING   4  max rows issued but not yet row_done
//  BW_NUM_ROW        8  width of row count
// PORTS
//  clk            in   1           clock
//  rstnn          in   1           async active-low reset
//  clear          in   1           sync abort to IDLE
//  enable         in   1           launch/advance enable
//  cmd_valid      in   1           command handshake
//  cmd_ready      out  1           high only in IDLE
//  cmd_base_addr  in   BW_ADDR     first row byte address
//  cmd_stride     in   BW_ADDR     byte distance between rows
//  cmd_num_row    in   BW_NUM_ROW  rows to load; 0 legal
//  cmd_alen       in   8           beats-1 per row
//  araddr         out  BW_ADDR     AR address
//  arlen          out  8           AR length
//  arsize         out  3           constant
//  arburst        out  2           constant INCR (2'b01)
//  arvalid        out  1           AR valid
//  arready        in   1           AR ready
//  txn_full       in   1           collector txn FIFO full
//  txn_push       out  1           pulse = AR handshake
//  txn_alen       out  8           alen of pushed row
//  txn_row_idx    out  BW_NUM_ROW  index of pushed row
//  txn_last_row   out  1           pushed row is last of command
//  row_done       in   1           collector consumed one row buffer
//  busy           out  1           state != IDLE
//  done           out  1           1-cycle pulse, command complete
//  err            out  1           sticky: alen clamp or credit underflow; cleared by clear
// BEHAVIOUR
//  Reset: IDLE; cmd_ready=1, arvalid=0, araddr=0, arlen=0, txn_push=0, done=0, busy=0, err=0, credits=0.
//  FSM IDLE -> ISSUE on cmd fire (num_row>0); IDLE -> DONE on cmd fire (num_row==0); ISSUE -> DRAIN on last AR fire;
//   DRAIN -> DONE when outstanding==0; DONE -> IDLE (done=1 for this one cycle).
//  Cmd accepted cycle T -> arvalid earliest T+1; back-to-back rows 1 AR/cycle while arready, credits, ~txn_full.
//  arvalid launch = ISSUE & enable & ~txn_full & (outstanding<MAX_OUTSTANDING).
//   Once asserted, arvalid/araddr/arlen hold until arready regardless of enable/txn_full/clear (AXI rule).
//  AR fire: txn_push=1 same cycle, txn_* valid; araddr += stride (mod 2^BW_ADDR wrap); row_idx++; outstanding++.
//  outstanding: +1 AR fire, -1 row_done, both same cycle -> unchanged; row_done at 0 -> ignored, err=1.
//  cmd_alen >= MAX_NUM_AXI_DATA -> clamped to MAX_NUM_AXI_DATA-1, err=1.
//  txn_last_row = (row_idx == num_row-1).
//  enable=0: no new launch, FSM frozen; pending AR still completes and is accounted.
//  clear: counters zeroed, FSM IDLE, err=0, no done pulse. If AR pending, deferred until its handshake (that row still pushed).
//  Reset mid-operation: immediate return to reset values; no drain.
// STRUCTURE
//  Shared include (dca_matrix_load_seq.vh): FSM state encodings, AXI_BURST_INCR, arsize calc function.
//  One sub-module: dca_credit_counter (inc/dec/clear, saturating at 0, underflow flag, not_full compare).
// TESTING
//  Base 0x1000, stride 0x40, rows 3, alen 3, arready=1 -> araddr 0x1000/0x1040/0x1080 consecutive cycles, last_row on 3rd; done after 3 row_done.
//  MAX_OUTSTANDING=4, rows 6, no row_done -> exactly 4 AR fires then stall; 1 row_done -> 5th AR next cycle.
//  rows 0 -> no arvalid, done pulse 2 cycles after cmd fire, busy high only between.
//  arready low 5 cycles, toggle enable and txn_full -> arvalid/araddr stable, single push on handshake.
//  Base 0xFFFFFFC0, stride 0x40, rows 2 -> araddr 0xFFFFFFC0 then 0x00000000.
//  Simultaneous AR fire + row_done -> outstanding unchanged; row_done at 0 -> err=1; alen 7 (MAX 4) -> arlen 3, err=1; clear -> err=0.

Source files
------------

// File: rtl/dca_matrix_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dca_matrix_load_sequencer_pkg
// Shared definitions for the DCA matrix-row load sequencer:
//   seq_state_t     : sequencer FSM states (also exported on state_dbg)
//   AXI_BURST_INCR  : AXI AR burst type used for every row
//   calc_arsize     : log2 of the AXI data-bus width in bytes
// -----------------------------------------------------------------------------
package dca_matrix_load_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Byte-count exponent of the data bus; e.g. 32-bit bus -> 3'd2.
    function automatic logic [2:0] calc_arsize(input int bw_data);
        int         bytes;
        logic [2:0] size;
        bytes = bw_data / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/dca_matrix_load_sequencer_credit_counter.sv
// -----------------------------------------------------------------------------
// dca_matrix_load_sequencer_credit_counter
// Counts rows issued on AR but not yet released by the row collector.
// Ports:
//   clk, rstnn  : clock, async active-low reset
//   clear       : synchronous zero
//   inc         : one row issued
//   dec         : one row released
//   count       : rows in flight
//   not_full    : count < MAX_COUNT, another row may be launched
//   underflow   : release requested while nothing in flight (ignored)
// -----------------------------------------------------------------------------
module dca_matrix_load_sequencer_credit_counter
    import dca_matrix_load_sequencer_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    parameter int BW_COUNT  = 3
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic [BW_COUNT-1:0] count,
    output logic                not_full,
    output logic                underflow
);

    always_comb begin
        underflow = dec & ~inc & (count == '0);
        not_full  = (count < BW_COUNT'(MAX_COUNT));
    end

    // Simultaneous inc and dec cancel; a dec at zero saturates.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc & ~dec) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dca_matrix_load_sequencer.sv
// -----------------------------------------------------------------------------
// dca_matrix_load_sequencer
// Turns one matrix-load command (base, stride, rows, beats) into one AXI AR
// burst per row, pushing the matching txn info to the row collector in the
// same cycle as each AR handshake. Rows in flight are capped by a credit
// counter that the collector returns through row_done.
// Ports:
//   clk, rstnn, clear, enable           : clock, async reset, sync abort, run enable
//   cmd_valid/cmd_ready, cmd_*          : command handshake and fields
//   araddr/arlen/arsize/arburst         : AXI AR payload
//   arvalid/arready                     : AXI AR handshake
//   txn_full                            : collector txn FIFO cannot take a push
//   txn_push, txn_alen/row_idx/last_row : txn info, valid when txn_push
//   row_done                            : collector released one row buffer
//   busy, done, err                     : status (done is a 1-cycle pulse, err sticky)
//   state_dbg                           : current FSM state
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising edge. cmd_ready does not depend on cmd_valid. arvalid
// never depends on arready, and once raised it holds (with araddr/arlen
// stable) until arready, whatever enable, txn_full or clear do meanwhile.
// txn_push has no ready; the launch is withheld while txn_full is high.
// -----------------------------------------------------------------------------
module dca_matrix_load_sequencer
    import dca_matrix_load_sequencer_pkg::*;
#(
    parameter int BW_ADDR          = 32,
    parameter int BW_AXI_DATA      = 32,
    parameter int MAX_NUM_AXI_DATA = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int BW_NUM_ROW       = 8
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [BW_ADDR-1:0]    cmd_base_addr,
    input  logic [BW_ADDR-1:0]    cmd_stride,
    input  logic [BW_NUM_ROW-1:0] cmd_num_row,
    input  logic [7:0]            cmd_alen,
    output logic [BW_ADDR-1:0]    araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic                  txn_full,
    output logic                  txn_push,
    output logic [7:0]            txn_alen,
    output logic [BW_NUM_ROW-1:0] txn_row_idx,
    output logic                  txn_last_row,
    input  logic                  row_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int         BW_CREDIT = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [7:0] ALEN_MAX  = 8'(MAX_NUM_AXI_DATA - 1);

    seq_state_t            state_q, state_d;
    logic                  ar_hold_q;      // AR offered last cycle and not yet taken
    logic                  clear_pend_q;   // clear seen while an AR was stuck
    logic [BW_ADDR-1:0]    addr_q, stride_q;
    logic [7:0]            alen_q;
    logic [BW_NUM_ROW-1:0] row_idx_q, last_idx_q;
    logic                  err_q, done_q;

    logic [BW_CREDIT-1:0]  credit_cnt;
    logic                  credit_not_full, credit_underflow;

    logic ar_stuck, clr_now, cmd_fire, launch, ar_fire, last_fire, alen_clamp;

    always_comb begin
        ar_stuck   = ar_hold_q & ~arready;
        // A clear cannot retract an offered AR, so it takes effect on the
        // handshake cycle of that AR (the row is still pushed).
        clr_now    = (clear | clear_pend_q) & ~ar_stuck;
        cmd_ready  = (state_q == ST_IDLE) & ~clear;
        cmd_fire   = cmd_valid & cmd_ready;
        launch     = (state_q == ST_ISSUE) & enable & ~txn_full & credit_not_full
                   & ~ar_hold_q & ~clear & ~clear_pend_q;
        arvalid    = ar_hold_q | launch;
        ar_fire    = arvalid & arready;
        last_fire  = ar_fire & (row_idx_q == last_idx_q);
        alen_clamp = (cmd_alen > ALEN_MAX);
    end

    always_comb begin
        state_d = state_q;
        if (clr_now) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cmd_fire) state_d = (cmd_num_row == '0) ? ST_DONE : ST_ISSUE;
                ST_ISSUE: if (last_fire) state_d = ST_DRAIN;
                ST_DRAIN: if (enable && (credit_cnt == '0)) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= ST_IDLE;
            ar_hold_q    <= 1'b0;
            clear_pend_q <= 1'b0;
            addr_q       <= '0;
            stride_q     <= '0;
            alen_q       <= '0;
            row_idx_q    <= '0;
            last_idx_q   <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // done is registered so the pulse lands on the first IDLE cycle.
            done_q  <= (state_q == ST_DONE) & ~clr_now;
            if (clr_now) begin
                ar_hold_q    <= 1'b0;
                clear_pend_q <= 1'b0;
                addr_q       <= '0;
                stride_q     <= '0;
                alen_q       <= '0;
                row_idx_q    <= '0;
                last_idx_q   <= '0;
                err_q        <= 1'b0;
            end else begin
                ar_hold_q    <= arvalid & ~arready;
                clear_pend_q <= clear_pend_q | (clear & ar_stuck);
                if (cmd_fire) begin
                    addr_q     <= cmd_base_addr;
                    stride_q   <= cmd_stride;
                    alen_q     <= alen_clamp ? ALEN_MAX : cmd_alen;
                    row_idx_q  <= '0;
                    last_idx_q <= cmd_num_row - 1'b1;
                end else if (ar_fire) begin
                    addr_q    <= addr_q + stride_q;
                    row_idx_q <= row_idx_q + 1'b1;
                end
                if ((cmd_fire & alen_clamp) | credit_underflow) err_q <= 1'b1;
            end
        end
    end

    dca_matrix_load_sequencer_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .BW_COUNT  (BW_CREDIT)
    ) u_credit (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clr_now),
        .inc       (ar_fire),
        .dec       (row_done),
        .count     (credit_cnt),
        .not_full  (credit_not_full),
        .underflow (credit_underflow)
    );

    always_comb begin
        araddr       = addr_q;
        arlen        = alen_q;
        arsize       = calc_arsize(BW_AXI_DATA);
        arburst      = AXI_BURST_INCR;
        txn_push     = ar_fire;
        txn_alen     = alen_q;
        txn_row_idx  = row_idx_q;
        txn_last_row = (row_idx_q == last_idx_q);
        busy         = (state_q != ST_IDLE);
        done         = done_q;
        err          = err_q;
        state_dbg    = state_q;
    end

endmodule
